seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Multiplexed 4-digit seven-segment scan driver for the lab board display. It consumes the one-cycle 500 Hz `tick` pulse produced by the clock-divider stage and rotates through the four digits, one per tick. Between digits it inserts an all-off ghost-suppression gap. It also decodes hex nibbles to segments, applies blanking and leading-zero suppression, and latches the displayed value once per frame so a digit cannot tear mid-scan.

## Interface

Parameters:
- `BLANK_CYCLES`, default 16: length of the all-off gap after each digit change, in `clk` cycles. Legal range is 1–255; the counter is 8 bits.

Ports:
- `clk` input, 1 bit: system clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset. Asserting it (0) forces the reset state immediately; release is synchronous to `clk`.
- `tick` input, 1 bit: one-cycle-high scan-advance pulse from the divider; 500 Hz nominal.
- `value` input, 16 bits: four hex digits; digit k is `value[4k+3:4k]`, digit 0 is rightmost.
- `dp` input, 4 bits: decimal point request per digit, active high.
- `blank` input, 4 bits: force digit k dark, active high.
- `lz_en` input, 1 bit: leading-zero suppression enable.
- `an_n` output, 4 bits: digit anodes, active low; bit k selects digit k.
- `seg_n` output, 7 bits: segments `{g,f,e,d,c,b,a}`, active low.
- `dp_n` output, 1 bit: decimal point segment, active low.
- `digit_idx` output, 2 bits: index of the digit currently owning the scan slot.
- `frame_load` output, 1 bit: one-cycle pulse in the cycle after the shadow registers capture.

## Operation

- FSM has two states: BLANK and DRIVE. An 8-bit gap counter `gcnt` and a 2-bit index `idx` drive `digit_idx`.
- Reset state:
  - state BLANK, `idx`=0, `gcnt`=`BLANK_CYCLES`-1.
  - `an_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1, `frame_load`=0.
  - Shadow value=0, shadow dp=0, shadow blank=0, shadow lz=0.
- BLANK:
  - Outputs are all off (`an_n`=F, `seg_n`=7F, `dp_n`=1).
  - Each edge with `gcnt`≠0 decrements `gcnt`.
  - At the edge where `gcnt`=0, go to DRIVE. If `idx`=0 on that edge, capture `value`/`dp`/`blank`/`lz_en` into the shadow registers and set `frame_load`=1 for the following cycle.
- DRIVE: hold the current digit from the shadow registers until a tick.
- A `tick` in either state:
  - `idx`←`idx`+1, wrapping from 3 to 0.
  - state←BLANK, `gcnt`←`BLANK_CYCLES`-1.
  - A tick during BLANK restarts the gap on the next digit.
- Digit drive in DRIVE, from the shadow copies:
  - `an_n[idx]`=0 unless the digit is suppressed. If suppressed, `an_n`=F and `seg_n`=7F.
  - `seg_n` = hex decode of the nibble. `dp_n` = ~shadow `dp[idx]`. `dp_n` is also forced to 1 when the digit is suppressed.
- Suppression of digit k applies when either holds:
  - shadow `blank[k]`=1; or
  - shadow lz=1, k≥1, and nibbles k..3 are all zero.
  - Digit 0 is never zero-suppressed.
- Hex decode (active low, `gfedcba`):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Input changes on `value`/`dp`/`blank`/`lz_en` have no visible effect until the next shadow capture.

## Timing

- All outputs are registered; no combinational path from any input to any output.
- Tick high during the cycle before edge E: `an_n`=F from E onward, for exactly `BLANK_CYCLES` cycles. The new digit is driven from edge E+`BLANK_CYCLES`.
- After reset release, the first edge begins the gap count. Digit 0 is driven from the `BLANK_CYCLES`-th edge, with a fresh capture and a `frame_load` pulse.
- `frame_load` is high for exactly one cycle per frame (per wrap to digit 0).
- Boundary cases:
  - A tick on the same edge as `gcnt`=0 in BLANK takes priority: it advances `idx` and reloads `gcnt`; no DRIVE entry, no capture.
  - Reset asserted mid-DRIVE or mid-BLANK blanks all outputs immediately (asynchronously) and returns to the reset state. Reset overrides a simultaneous tick.
  - Ticks spaced closer than `BLANK_CYCLES` keep the display dark; each tick still advances `idx`.

## Test plan

- **Reset to first digit.** `BLANK_CYCLES`=4, `value`=16'h1234, no ticks → `an_n`=F for 4 cycles after release. Then `an_n`=4'b1110, `seg_n`=7'b0011001 ('4'), with one `frame_load` pulse.
- **Full scan.** Ticks every 20 cycles → digit order 0,1,2,3,0. Each digit shows 4,3,2,1 on the correct anode, preceded by exactly 4 dark cycles.
- **Frame latch.** Change `value` to 16'hABCD while digit 2 is displayed → digits 2 and 3 still show 2 and 1. After the wrap, digit 0 shows 'd' (0100001) with a new `frame_load`.
- **Leading zeros, blanking, decimal point.** `value`=16'h0070, `lz_en`=1 → digits 3 and 2 dark, digit 1 shows '7', digit 0 shows '0'. Then `blank`=4'b0001 with `dp`=4'b0001 → digit 0 dark and `dp_n`=1.
- **Tick collision.** Tick arrives on the same edge where `gcnt`=0 → `idx` advances and the display stays dark 4 more cycles; no DRIVE for the skipped digit.
- **Async reset mid-scan.** Assert `reset`=0 while digit 2 is driving, between clock edges → `an_n`=F, `seg_n`=7F, `dp_n`=1, `digit_idx`=0 without waiting for a clock edge.

Source files
------------

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Four-digit multiplexed seven-segment scan driver.
//                - Moves to the next digit on each one-cycle `tick` pulse.
//                - Inserts an all-off gap of BLANK_CYCLES clocks after every
//                  digit change to stop ghosting.
//                - Decodes hex digits and applies per-digit blanking and
//                  leading-zero suppression.
//                - Captures the display inputs once per frame, so a value
//                  change cannot split one frame between old and new digits.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BLANK_CYCLES : gap length in clk cycles after a digit change (1..255)
//  Ports
//    clk        in   system clock, rising edge
//    reset      in   asynchronous reset, active low
//    tick       in   one-cycle scan-advance pulse
//    value      in   [15:0] four hex digits, digit 0 in bits [3:0]
//    dp         in   [3:0] decimal-point request per digit, active high
//    blank      in   [3:0] force digit dark, active high
//    lz_en      in   leading-zero suppression enable
//    an_n       out  [3:0] digit anodes, active low
//    seg_n      out  [6:0] segments {g,f,e,d,c,b,a}, active low
//    dp_n       out  decimal-point segment, active low
//    digit_idx  out  [1:0] digit that owns the current scan slot
//    frame_load out  one-cycle pulse in the cycle after a frame capture
// ============================================================================
module seg_scan_driver #(
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        lz_en,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [1:0]  digit_idx,
    output logic        frame_load
);

    localparam logic [7:0] GAP_RELOAD = 8'(BLANK_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  gcnt;
    logic [1:0]  idx;

    // Frame shadow copies of the display inputs
    logic [15:0] sh_value;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_blank;
    logic        sh_lz;

    // Data used on the edge that enters DRIVE. On digit 0 this edge also
    // captures a new frame, so that digit uses the live inputs.
    logic [15:0] ent_value;
    logic [3:0]  ent_dp;
    logic [3:0]  ent_blank;
    logic        ent_lz;
    logic        ent_off;
    logic [3:0]  ent_an;
    logic [6:0]  ent_seg;
    logic        ent_dp_n;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // A digit is dark when it is blanked, or when leading-zero suppression
    // is on and this digit and every digit to its left are zero. Digit 0 is
    // never zero-suppressed, so a value of 0 still shows a single '0'.
    function automatic logic digit_dark(input logic [15:0] v,
                                        input logic [3:0]  bl,
                                        input logic        lz,
                                        input logic [1:0]  k);
        logic lead_zero;
        case (k)
            2'd1:    lead_zero = (v[15:4]  == 12'h000);
            2'd2:    lead_zero = (v[15:8]  == 8'h00);
            2'd3:    lead_zero = (v[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
        return bl[k] | (lz & lead_zero);
    endfunction

    always_comb begin
        ent_value = sh_value;
        ent_dp    = sh_dp;
        ent_blank = sh_blank;
        ent_lz    = sh_lz;
        if (idx == 2'd0) begin
            ent_value = value;
            ent_dp    = dp;
            ent_blank = blank;
            ent_lz    = lz_en;
        end
        ent_off  = digit_dark(ent_value, ent_blank, ent_lz, idx);
        ent_an   = 4'hF;
        ent_seg  = 7'h7F;
        ent_dp_n = 1'b1;
        if (!ent_off) begin
            ent_an   = ~(4'b0001 << idx);
            ent_seg  = hex7(ent_value[{idx, 2'b00} +: 4]);
            ent_dp_n = ~ent_dp[idx];
        end
    end

    assign digit_idx = idx;

    // The display outputs are set when DRIVE is entered and forced dark on
    // every tick. DRIVE holds them unchanged, because the shadow registers
    // only change on the edge that enters DRIVE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_BLANK;
            gcnt       <= GAP_RELOAD;
            idx        <= 2'd0;
            sh_value   <= 16'h0000;
            sh_dp      <= 4'h0;
            sh_blank   <= 4'h0;
            sh_lz      <= 1'b0;
            an_n       <= 4'hF;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_load <= 1'b0;
        end else begin
            frame_load <= 1'b0;
            if (tick) begin
                // A tick wins over a gap that expires on the same edge.
                idx   <= idx + 2'd1;
                state <= ST_BLANK;
                gcnt  <= GAP_RELOAD;
                an_n  <= 4'hF;
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
            end else if (state == ST_BLANK) begin
                if (gcnt != 8'd0) begin
                    gcnt <= gcnt - 8'd1;
                end else begin
                    state <= ST_DRIVE;
                    if (idx == 2'd0) begin
                        sh_value   <= value;
                        sh_dp      <= dp;
                        sh_blank   <= blank;
                        sh_lz      <= lz_en;
                        frame_load <= 1'b1;
                    end
                    an_n  <= ent_an;
                    seg_n <= ent_seg;
                    dp_n  <= ent_dp_n;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Self-checking bench for seg_scan_driver. It runs the
//                directed scenarios first, then random tick and input
//                traffic. Each cycle is compared with a timeline model that
//                records when the last gap started and which digit owns
//                the scan slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int B = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_load;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16];
    logic [3:0] scan_an [4];
    logic [6:0] scan_seg [4];

    // Model: edge number, edge on which the current gap started, owning digit
    int          m_n;
    int          m_gap;
    int          m_idx;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  m_bl;
    logic        m_lz;
    logic        m_fl;
    logic        m_drive;

    always #5 clk = ~clk;

    seg_scan_driver #(.BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .lz_en      (lz_en),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .digit_idx  (digit_idx),
        .frame_load (frame_load)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dut_bundle();
        return {1'b0, an_n, seg_n, dp_n, digit_idx, frame_load};
    endfunction

    function automatic logic [15:0] model_bundle();
        logic [3:0]  an;
        logic [6:0]  sg;
        logic        d;
        logic        off;
        logic [15:0] upper;
        upper = m_val >> (4 * m_idx);
        off   = m_bl[m_idx] || (m_lz && m_idx >= 1 && upper == 16'h0000);
        an    = 4'hF;
        sg    = 7'h7F;
        d     = 1'b1;
        if (m_drive && !off) begin
            an[m_idx] = 1'b0;
            sg        = seg_tab[upper[3:0]];
            d         = ~m_dp[m_idx];
        end
        return {1'b0, an, sg, d, 2'(m_idx), m_fl};
    endfunction

    task automatic model_reset();
        m_n = 0; m_gap = 0; m_idx = 0;
        m_val = '0; m_dp = '0; m_bl = '0; m_lz = 1'b0;
        m_fl = 1'b0; m_drive = 1'b0;
    endtask

    // One clock: drive tick, advance the model on the edge, compare 1 ns later.
    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        m_n++;
        m_fl = 1'b0;
        if (t) begin
            m_idx   = (m_idx + 1) % 4;
            m_gap   = m_n;
            m_drive = 1'b0;
        end else begin
            if (m_n == m_gap + B && m_idx == 0) begin
                m_val = value; m_dp = dp; m_bl = blank; m_lz = lz_en;
                m_fl  = 1'b1;
            end
            m_drive = (m_n >= m_gap + B);
        end
        #1;
        tick = 1'b0;
        check("scan", dut_bundle(), model_bundle());
    endtask

    // Tick, then wait out the gap so the next digit has just been driven.
    task automatic to_next_digit();
        step(1'b1);
        repeat (B) step(1'b0);
    endtask

    task automatic hold(input int n);
        repeat (n) step(1'b0);
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        scan_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        scan_seg = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0100001};

        reset = 1'b1; tick = 1'b0; value = 16'h1234;
        dp = 4'h0; blank = 4'h0; lz_en = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_bundle(), {1'b0, 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        reset = 1'b1;
        model_reset();

        // Reset release to first digit
        repeat (B - 1) begin
            step(1'b0);
            check("first_dark", 16'(an_n), 16'h000F);
        end
        step(1'b0);
        check("first_an",  16'(an_n), 16'h000E);
        check("first_seg", 16'(seg_n), 16'h0019);
        check("first_fl",  16'(frame_load), 16'h0001);
        step(1'b0);
        check("fl_once", 16'(frame_load), 16'h0000);

        // Full scan every 20 cycles; value changes while digit 2 is shown
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            repeat (B - 1) begin
                step(1'b0);
                check("gap_dark", 16'(an_n), 16'h000F);
            end
            step(1'b0);
            check("scan_an",  16'(an_n), 16'(scan_an[k]));
            check("scan_seg", 16'(seg_n), 16'(scan_seg[k]));
            if (k == 3) check("latch_fl", 16'(frame_load), 16'h0001);
            if (k == 1) value = 16'hABCD;
            hold(20 - B - 1);
        end

        // Leading-zero suppression, then blanking with decimal point
        value = 16'h0070; lz_en = 1'b1;
        repeat (4) begin to_next_digit(); hold(15); end
        to_next_digit();
        check("lz_d1_an",  16'(an_n), 16'h000D);
        check("lz_d1_seg", 16'(seg_n), 16'h0078);
        hold(15);
        to_next_digit();
        check("lz_d2_an", 16'(an_n), 16'h000F);
        hold(15);
        to_next_digit();
        check("lz_d3_an", 16'(an_n), 16'h000F);
        hold(15);
        to_next_digit();
        check("lz_d0_an",  16'(an_n), 16'h000E);
        check("lz_d0_seg", 16'(seg_n), 16'h0040);
        hold(15);
        blank = 4'b0001; dp = 4'b0001;
        repeat (3) begin to_next_digit(); hold(15); end
        to_next_digit();
        check("blank_d0_an", 16'(an_n), 16'h000F);
        check("blank_d0_dp", 16'(dp_n), 16'h0001);
        hold(15);

        // Tick collision: second tick lands on the gap-expiry edge
        value = 16'h1234; lz_en = 1'b0; blank = 4'h0; dp = 4'h0;
        repeat (4) begin to_next_digit(); hold(15); end
        step(1'b1);
        hold(B - 1);
        step(1'b1);
        check("coll_idx", 16'(digit_idx), 16'h0002);
        check("coll_an",  16'(an_n), 16'h000F);
        repeat (B - 1) begin
            step(1'b0);
            check("coll_dark", 16'(an_n), 16'h000F);
        end
        step(1'b0);
        check("coll_drive_an", 16'(an_n), 16'h000B);
        hold(3);

        // Asynchronous reset while digit 2 is driving, between edges
        #2 reset = 1'b0;
        #1;
        check("async_rst", dut_bundle(), {1'b0, 4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                value = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 15) == 0)
                blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 31) == 0) lz_en = 1'($urandom);
            step($urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
